// File: rtl/rv_pkg.sv
// Shared register-file constants and a small decode helper for the
// writeback arbiter.
package rv_pkg;

  localparam int                XLEN     = 32;
  localparam int                REG_AW   = 5;
  localparam int                NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    logic [NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO for LLU results; DEPTH must be a power of two
// so pointers wrap naturally.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic                    do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the WB stage (priority) and
// buffered LLU results; tracks LLU destinations and guards against starvation.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN         = rv_pkg::XLEN,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_we,
  input  logic [REG_AW-1:0]           wb_rd,
  input  logic [XLEN-1:0]             wb_data,
  input  logic                        llu_valid,
  input  logic [REG_AW-1:0]           llu_rd,
  input  logic [XLEN-1:0]             llu_data,
  output logic                        llu_ready,
  input  logic                        issue_valid,
  input  logic [REG_AW-1:0]           issue_rd,
  input  logic [REG_AW-1:0]           rs1,
  input  logic [REG_AW-1:0]           rs2,
  input  logic [REG_AW-1:0]           dec_rd,
  output logic                        hazard,
  output logic                        stall_o,
  output logic                        rf_we,
  output logic [REG_AW-1:0]           rf_a3,
  output logic [XLEN-1:0]             rf_wd3,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam int EW = REG_AW + XLEN;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [EW-1:0]       head;
  logic [REG_AW-1:0]   head_rd;
  logic [XLEN-1:0]     head_data;
  logic                fifo_full, fifo_empty;
  logic                push, wb_sel, drain;

  // rd=0 results are acknowledged but never stored
  assign push   = llu_valid & llu_ready & (llu_rd != REG_ZERO);
  assign wb_sel = wb_we & (wb_rd != REG_ZERO);
  assign drain  = ~rst & ~wb_sel & ~fifo_empty;

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (drain),
    .wdata ({llu_rd, llu_data}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_rd   = head[EW-1:XLEN];
  assign head_data = head[XLEN-1:0];
  assign llu_ready = ~rst & ~fifo_full;

  always_comb begin
    rf_we  = 1'b0;
    rf_a3  = '0;
    rf_wd3 = '0;
    if (wb_sel && !rst) begin
      rf_we  = 1'b1;
      rf_a3  = wb_rd;
      rf_wd3 = wb_data;
    end else if (drain) begin
      rf_we  = 1'b1;
      rf_a3  = head_rd;
      rf_wd3 = head_data;
    end
  end

  // set after clear so a same-cycle issue to the draining rd stays busy
  always_comb begin
    busy_d = busy_q;
    if (drain) busy_d = busy_d & ~rd_onehot(head_rd);
    if (issue_valid && issue_rd != REG_ZERO) busy_d = busy_d | rd_onehot(issue_rd);
    busy_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || drain)               starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      starve_q <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
    end
  end

  assign hazard  = ~rst & (busy_q[rs1] | busy_q[rs2] | busy_q[dec_rd]);
  assign stall_o = ~rst & (starve_q == SW'(STARVE_LIMIT));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus queues expected writes and signal checks, a
// negedge monitor pops and compares them.
module tb_regfile_wb_arbiter;

  localparam int S_WE = 0, S_READY = 1, S_CNT = 2, S_HAZ = 3, S_STALL = 4, S_PEND = 5;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
  typedef struct { int sig; int unsigned val; } chk_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wb_we = 1'b0, llu_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  wb_rd = '0, llu_rd = '0, issue_rd = '0, rs1 = '0, rs2 = '0, dec_rd = '0;
  logic [31:0] wb_data = '0, llu_data = '0;
  logic        llu_ready, hazard, stall_o, rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [1:0]  fifo_count;

  wr_t  exp_wr[$];
  chk_t chk_q[$];
  chk_t c;
  wr_t  w;
  int   vectors = 0, miscompares = 0;

  regfile_wb_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .dec_rd(dec_rd),
    .hazard(hazard), .stall_o(stall_o),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && issue_valid && issue_rd != 5'd0)
      assert (!dut.busy_q[issue_rd]) else $error("illegal issue to busy rd %0d", issue_rd);

  function automatic int unsigned sig_val(input int s);
    case (s)
      S_WE:    return {31'd0, rf_we};
      S_READY: return {31'd0, llu_ready};
      S_CNT:   return {30'd0, fifo_count};
      S_HAZ:   return {31'd0, hazard};
      S_STALL: return {31'd0, stall_o};
      default: return exp_wr.size();
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_WE:    return "rf_we";
      S_READY: return "llu_ready";
      S_CNT:   return "fifo_count";
      S_HAZ:   return "hazard";
      S_STALL: return "stall_o";
      default: return "pending_writes";
    endcase
  endfunction

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      vectors++;
      if (sig_val(c.sig) != c.val) begin
        miscompares++;
        $display("FAIL %s @%0t: got %0d want %0d", sig_name(c.sig), $time, sig_val(c.sig), c.val);
      end
    end
    vectors++;
    if (rf_we) begin
      if (exp_wr.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write @%0t: got rd=%0d data=%h want none", $time, rf_a3, rf_wd3);
      end else begin
        w = exp_wr.pop_front();
        if (rf_a3 != w.rd || rf_wd3 != w.data) begin
          miscompares++;
          $display("FAIL write @%0t: got rd=%0d data=%h want rd=%0d data=%h",
                   $time, rf_a3, rf_wd3, w.rd, w.data);
        end
      end
    end else if (rf_a3 != 5'd0 || rf_wd3 != 32'd0) begin
      miscompares++;
      $display("FAIL idle_port @%0t: got rd=%0d data=%h want 0/0", $time, rf_a3, rf_wd3);
    end
  end

  task automatic step();
    @(posedge clk); #1;
    wb_we = 0; wb_rd = 0; wb_data = 0; llu_valid = 0; llu_rd = 0; llu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0; dec_rd = 0;
  endtask

  task automatic ex(input int s, input int unsigned v);
    chk_q.push_back('{s, v});
  endtask

  task automatic ew(input logic [4:0] rd, input logic [31:0] d);
    exp_wr.push_back('{rd, d});
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_we = 1; wb_rd = rd; wb_data = d;
  endtask

  task automatic llu(input logic [4:0] rd, input logic [31:0] d);
    llu_valid = 1; llu_rd = rd; llu_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset then idle
    step();
    step(); ex(S_WE, 0); ex(S_READY, 0); ex(S_HAZ, 0); ex(S_STALL, 0);
    step(); rst = 0; ex(S_WE, 0); ex(S_READY, 1); ex(S_CNT, 0); ex(S_HAZ, 0); ex(S_STALL, 0);

    // wb priority over a same-cycle LLU push
    step(); wb(3, 32'hAAAA); llu(7, 32'h1234); ew(3, 32'hAAAA); ew(7, 32'h1234);
            ex(S_CNT, 0); ex(S_WE, 1);
    step(); ex(S_CNT, 1); ex(S_WE, 1);
    step(); ex(S_CNT, 0); ex(S_WE, 0);

    // scoreboard set / clear / set-wins
    step(); issue_valid = 1; issue_rd = 7;
    step(); rs1 = 7; ex(S_HAZ, 1); llu(7, 32'h77); ew(7, 32'h77);
    step(); rs1 = 7; ex(S_HAZ, 1); ex(S_WE, 1);
    step(); rs1 = 7; ex(S_HAZ, 0); ex(S_WE, 0);
    step(); issue_valid = 1; issue_rd = 12;
    step(); dec_rd = 12; ex(S_HAZ, 1);
    step(); rs2 = 12; ex(S_HAZ, 1);
    step(); llu(9, 32'h99); ew(9, 32'h99);
    step(); issue_valid = 1; issue_rd = 9; rs1 = 9; ex(S_HAZ, 0); ex(S_WE, 1);
    step(); rs1 = 9; ex(S_HAZ, 1); ex(S_CNT, 0);

    // full FIFO with a held third result
    step(); wb(1, 32'h11); llu(5, 32'h55);
            ew(1, 32'h11); ew(2, 32'h22); ew(3, 32'h33); ew(4, 32'h44);
            ew(5, 32'h55); ew(6, 32'h66); ew(8, 32'h88);
    step(); wb(2, 32'h22); llu(6, 32'h66); ex(S_CNT, 1); ex(S_READY, 1);
    step(); wb(3, 32'h33); llu(8, 32'h88); ex(S_CNT, 2); ex(S_READY, 0);
    step(); wb(4, 32'h44); llu(8, 32'h88); ex(S_CNT, 2); ex(S_READY, 0);
    step(); llu(8, 32'h88); ex(S_READY, 0); ex(S_WE, 1); ex(S_CNT, 2);
    step(); llu(8, 32'h88); ex(S_READY, 1); ex(S_CNT, 1); ex(S_WE, 1);
    step(); ex(S_CNT, 1); ex(S_WE, 1);
    step(); ex(S_CNT, 0); ex(S_WE, 0);

    // starvation: stall after 4 blocked cycles
    step(); wb(11, 32'hB0); llu(10, 32'hA0); ew(11, 32'hB0);
    for (int i = 1; i <= 5; i++) begin
      step(); wb(11, 32'hB0 + i); ew(11, 32'hB0 + i); ex(S_STALL, (i == 5) ? 1 : 0);
    end
    step(); ew(10, 32'hA0); ex(S_STALL, 1); ex(S_WE, 1);
    step(); ex(S_STALL, 0); ex(S_WE, 0); ex(S_CNT, 0);

    // x0 writes do not block, rd=0 pushes are dropped
    step(); wb(14, 32'hE0); llu(13, 32'hD0); ew(14, 32'hE0); ew(13, 32'hD0);
    step(); wb(0, 32'hDEAD); ex(S_WE, 1); ex(S_CNT, 1);
    step(); llu(0, 32'hFF); ex(S_CNT, 0); ex(S_WE, 0); ex(S_READY, 1);
    step(); ex(S_CNT, 0); ex(S_WE, 0);

    // reset with two queued results
    step(); wb(15, 32'hF0); llu(16, 32'h16); ew(15, 32'hF0);
    step(); wb(17, 32'hF1); llu(18, 32'h18); ew(17, 32'hF1); ex(S_CNT, 1);
    step(); rst = 1; rs1 = 12; ex(S_WE, 0); ex(S_READY, 0); ex(S_HAZ, 0); ex(S_STALL, 0);
    step(); rst = 0; rs1 = 12; ex(S_CNT, 0); ex(S_WE, 0); ex(S_READY, 1); ex(S_HAZ, 0);
    step(); rs2 = 9; ex(S_WE, 0); ex(S_HAZ, 0);
    step(); ex(S_PEND, 0);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we/addr/data) between two writers: the pipeline writeback stage and the long-latency unit (LLU, mul/div/load-miss).
- Buffers LLU results in a small FIFO and guards against starvation.
- Keeps a busy scoreboard of LLU destinations so decode can detect hazards.
- Sits between the WB stage/LLU and register_file; also drives a decode-side hazard output and a pipeline stall output.

Parameters:
- XLEN, 32, data width.
- DEPTH, 2, LLU result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive blocked cycles before a stall is requested (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- wb_we  in  1  pipeline writeback valid; no backpressure, always has priority.
- wb_rd  in  5  pipeline writeback destination.
- wb_data  in  XLEN  pipeline writeback data.
- llu_valid  in  1  LLU result valid.
- llu_rd  in  5  LLU result destination.
- llu_data  in  XLEN  LLU result data.
- llu_ready  out  1  FIFO can accept an LLU result.
- issue_valid  in  1  an LLU op is issued this cycle.
- issue_rd  in  5  destination of the issued LLU op.
- rs1, rs2  in  5 each  decode source registers to check.
- dec_rd  in  5  decode destination to check (WAW).
- hazard  out  1  busy[rs1] | busy[rs2] | busy[dec_rd], combinational.
- stall_o  out  1  request that upstream idle the WB stage.
- rf_we  out  1  to register file WE3.
- rf_a3  out  5  to register file A3.
- rf_wd3  out  XLEN  to register file WD3.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset: while rst=1, FIFO count, busy[31:0] and starve_cnt are cleared, and rf_we=0, llu_ready=0, stall_o=0, hazard=0. Reset mid-operation drops all queued LLU results.
- Write-port mux (combinational, zero latency):
  - If wb_we=1 and wb_rd≠0, the port carries wb_rd/wb_data.
  - Else if the FIFO is non-empty, the port carries the FIFO head, which is popped this cycle ("drain").
  - Else rf_we=0.
  - wb_we=1 with wb_rd=0 writes nothing and does not block the FIFO. x0 is never written.
- rf_a3/rf_wd3 equal the selected source; both are 0 when rf_we=0.
- LLU intake:
  - llu_ready = (count < DEPTH), from registered count. A push happens when llu_valid & llu_ready.
  - A push with llu_rd=0 is accepted and discarded; it is not enqueued and does not clear busy[0].
  - No same-cycle bypass: minimum latency from push to rf_we is 1 cycle.
- FIFO: push and pop in the same cycle are allowed, and count is unchanged. Pointers wrap modulo DEPTH. Entries are strictly in order.
- Scoreboard (busy[31:0] registered):
  - Set: issue_valid & issue_rd≠0 sets busy[issue_rd] next cycle.
  - Clear: a drain writing rd clears busy[rd] next cycle.
  - Set and clear of the same rd in one cycle: set wins.
  - busy[0] is always 0.
  - Issue to an rd that is already busy is illegal (upstream must honour hazard); the bench flags it with an assertion.
- Starvation:
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and the port is taken by wb.
  - starve_cnt clears on any drain or when the FIFO is empty.
  - stall_o = (starve_cnt == STARVE_LIMIT), so it is registered-derived.
  - Upstream guarantees wb_we=0 from the cycle after stall_o rises. The drain then occurs and stall_o falls the following cycle.
- Simultaneous events: wb write, FIFO drain blocked, LLU push, and issue may all occur in one cycle; each updates its state independently per the rules above.

Decomposition:
- Package rv_pkg: XLEN=32, REG_AW=5, NUM_REGS=32, REG_ZERO=5'd0.
- One sub-module, wb_fifo: parameterised sync FIFO (DEPTH × {5-bit rd, XLEN data}) with push/pop/count/full/empty and synchronous active-high reset.
- Scoreboard, mux and starvation counter stay in the top module.

Test Plan:
1. Reset then idle: apply rst 2 cycles, then release → rf_we=0, llu_ready=1, fifo_count=0, hazard=0, stall_o=0.
2. Priority: wb_we=1 rd=3 data=0xAAAA, and the same cycle llu push rd=7 data=0x1234 → that cycle rf_we/rf_a3=3/0xAAAA. Next cycle with wb idle → rf_a3=7, rf_wd3=0x1234, fifo_count returns to 0.
3. Scoreboard:
   - Issue rd=7 → next cycle rs1=7 gives hazard=1.
   - LLU result rd=7 drains → hazard=0 the cycle after the drain.
   - Issue rd=9 in the same cycle a drain writes rd=9 → busy[9] stays 1.
4. Full FIFO: push rd=5 and rd=6 while wb_we=1 every cycle → llu_ready=0 at count=2. A third llu_valid is held with no loss. Order of writes is 5 then 6.
5. Starvation: FIFO holds 1 entry, wb_we=1 (rd≠0) continuously → stall_o=1 after exactly STARVE_LIMIT=4 blocked cycles. Bench drops wb_we → drain next cycle, stall_o=0 the cycle after.
6. x0 and reset mid-op:
   - wb_we=1 rd=0 with the FIFO non-empty → the FIFO drains that cycle.
   - LLU push rd=0 → fifo_count unchanged, no write.
   - rst with count=2 → count=0 and no rf_we after reset.
